// File: rtl/draw_pkg.sv
// Shared definitions for the landing-pad overlay.
// Holds the coordinate/colour widths, the default colours, the packed pad
// geometry record and a helper that builds the reset geometry for one pad.
package draw_pkg;

   localparam int CNT_W = 11;          // hcount/vcount and geometry width
   localparam int RGB_W = 12;          // 4:4:4 pixel
   localparam int SUM_W = CNT_W + 1;   // edge sums carry one extra bit so 2047+w never wraps

   localparam logic [RGB_W-1:0] COLOR_PAD_DEF = 12'h0f0;
   localparam logic [RGB_W-1:0] COLOR_TGT_DEF = 12'hff0;

   typedef struct packed {
      logic [CNT_W-1:0] x;   // left edge
      logic [CNT_W-1:0] y;   // top edge
      logic [CNT_W-1:0] w;   // width, 0 makes the pad invisible
   } pad_geom_t;

   // Reset geometry of pad idx: pads are spaced evenly along one row.
   function automatic pad_geom_t pad_reset_geom(input int idx, input int x0, input int x_step,
                                                input int y0, input int w0);
      pad_geom_t g;
      g.x = CNT_W'(x0 + idx * x_step);
      g.y = CNT_W'(y0);
      g.w = CNT_W'(w0);
      return g;
   endfunction

endpackage

// File: rtl/pad_hit_cmp.sv
// Combinational rectangle compare for a single pad.
// Ports:
//   en      pad draw enable
//   hcount  current pixel column
//   vcount  current pixel row
//   geom    pad geometry (x, y, w); height is the PAD_H parameter
//   hit     pixel lies inside the enabled pad
module pad_hit_cmp
   import draw_pkg::*;
#(
   parameter int PAD_H = 20
) (
   input  logic             en,
   input  logic [CNT_W-1:0] hcount,
   input  logic [CNT_W-1:0] vcount,
   input  pad_geom_t        geom,
   output logic             hit
);

   logic [SUM_W-1:0] x_end_s;
   logic [SUM_W-1:0] y_end_s;

   // Right/bottom edges are exclusive and computed one bit wider than the
   // coordinates, so a pad at the right screen edge does not wrap to column 0.
   assign x_end_s = {1'b0, geom.x} + {1'b0, geom.w};
   assign y_end_s = {1'b0, geom.y} + SUM_W'(PAD_H);

   assign hit = en
              & (hcount >= geom.x) & ({1'b0, hcount} < x_end_s)
              & (vcount >= geom.y) & ({1'b0, vcount} < y_end_s);

endmodule

// File: rtl/draw_landing_pads.sv
// Landing-pad overlay stage of the VGA draw chain.
// Draws NUM_PADS rectangles with runtime geometry. Geometry writes go to a
// shadow bank which is copied to the active bank on the rising edge of
// vblnk_in, so a pad never changes mid-frame. One target pad can blink at a
// rate counted in frames. All outputs are delayed by exactly 2 clocks.
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   pad_en                   per-pad enable, applied to the current pixel
//   tgt_valid, tgt_idx       blink enable and target pad index
//   cfg_we/idx/x/y/w         shadow bank write port
//   *_in                     upstream timing and pixel
//   *_out                    timing and pixel with pads drawn
//   pad_hit, pad_hit_idx     winning pad of the output pixel (idx 0 when no hit)
module draw_landing_pads
   import draw_pkg::*;
#(
   parameter int               NUM_PADS     = 4,
   parameter int               IDX_W        = 2,
   parameter int               PAD_X0       = 10,
   parameter int               PAD_X_STEP   = 155,
   parameter int               PAD_Y0       = 560,
   parameter int               PAD_W0       = 115,
   parameter int               PAD_H        = 20,
   parameter int               BLINK_FRAMES = 30,
   parameter logic [RGB_W-1:0] COLOR_PAD    = COLOR_PAD_DEF,
   parameter logic [RGB_W-1:0] COLOR_TGT    = COLOR_TGT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_PADS-1:0] pad_en,
   input  logic                tgt_valid,
   input  logic [IDX_W-1:0]    tgt_idx,
   input  logic                cfg_we,
   input  logic [IDX_W-1:0]    cfg_idx,
   input  logic [CNT_W-1:0]    cfg_x,
   input  logic [CNT_W-1:0]    cfg_y,
   input  logic [CNT_W-1:0]    cfg_w,
   input  logic [CNT_W-1:0]    hcount_in,
   input  logic [CNT_W-1:0]    vcount_in,
   input  logic                hsync_in,
   input  logic                vsync_in,
   input  logic                hblnk_in,
   input  logic                vblnk_in,
   input  logic [RGB_W-1:0]    rgb_in,
   output logic [CNT_W-1:0]    hcount_out,
   output logic [CNT_W-1:0]    vcount_out,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                hblnk_out,
   output logic                vblnk_out,
   output logic [RGB_W-1:0]    rgb_out,
   output logic                pad_hit,
   output logic [IDX_W-1:0]    pad_hit_idx
);

   localparam int             FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   pad_geom_t             shadow_r [NUM_PADS];
   pad_geom_t             active_r [NUM_PADS];
   logic                  vblnk_prev_r;
   logic                  vsync_prev_r;
   logic [FC_W-1:0]       frame_cnt_r;
   logic                  blink_on_r;
   logic                  commit_s;
   logic                  frame_tick_s;

   logic [NUM_PADS-1:0]   hit_s;

   logic [NUM_PADS-1:0]   hit_s1_r;
   logic [RGB_W-1:0]      rgb_s1_r;
   logic [CNT_W-1:0]      hcount_s1_r;
   logic [CNT_W-1:0]      vcount_s1_r;
   logic                  hsync_s1_r;
   logic                  vsync_s1_r;
   logic                  hblnk_s1_r;
   logic                  vblnk_s1_r;
   logic                  tgt_valid_s1_r;
   logic [IDX_W-1:0]      tgt_idx_s1_r;
   logic                  blink_s1_r;

   logic                  win_hit_s;
   logic [IDX_W-1:0]      win_idx_s;
   logic [RGB_W-1:0]      rgb_nxt_s;

   assign commit_s     = vblnk_in & ~vblnk_prev_r;
   assign frame_tick_s = vsync_in & ~vsync_prev_r;

   // Shadow/active geometry banks. A write in the commit cycle lands only in
   // the shadow (active takes the pre-write shadow), so it shows a frame later.
   // Writes to indices >= NUM_PADS match no bank entry and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            shadow_r[i] <= pad_reset_geom(i, PAD_X0, PAD_X_STEP, PAD_Y0, PAD_W0);
            active_r[i] <= pad_reset_geom(i, PAD_X0, PAD_X_STEP, PAD_Y0, PAD_W0);
         end
      end else begin
         for (int i = 0; i < NUM_PADS; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
               shadow_r[i] <= '{x: cfg_x, y: cfg_y, w: cfg_w};
            end
            if (commit_s) begin
               active_r[i] <= shadow_r[i];
            end
         end
      end
   end

   // Edge detectors for vblank (commit) and vsync (frame counting).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vblnk_prev_r <= 1'b0;
         vsync_prev_r <= 1'b0;
      end else begin
         vblnk_prev_r <= vblnk_in;
         vsync_prev_r <= vsync_in;
      end
   end

   // Frame counter and blink phase; runs regardless of tgt_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_r <= '0;
         blink_on_r  <= 1'b0;
      end else if (frame_tick_s) begin
         if (frame_cnt_r == FC_LAST) begin
            frame_cnt_r <= '0;
            blink_on_r  <= ~blink_on_r;
         end else begin
            frame_cnt_r <= frame_cnt_r + FC_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
      pad_hit_cmp #(
         .PAD_H (PAD_H)
      ) u_cmp (
         .en     (pad_en[g]),
         .hcount (hcount_in),
         .vcount (vcount_in),
         .geom   (active_r[g]),
         .hit    (hit_s[g])
      );
   end

   // Stage 1: register hit vector, pixel, timing and target controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_s1_r       <= '0;
         rgb_s1_r       <= '0;
         hcount_s1_r    <= '0;
         vcount_s1_r    <= '0;
         hsync_s1_r     <= 1'b0;
         vsync_s1_r     <= 1'b0;
         hblnk_s1_r     <= 1'b0;
         vblnk_s1_r     <= 1'b0;
         tgt_valid_s1_r <= 1'b0;
         tgt_idx_s1_r   <= '0;
         blink_s1_r     <= 1'b0;
      end else begin
         hit_s1_r       <= hit_s;
         rgb_s1_r       <= rgb_in;
         hcount_s1_r    <= hcount_in;
         vcount_s1_r    <= vcount_in;
         hsync_s1_r     <= hsync_in;
         vsync_s1_r     <= vsync_in;
         hblnk_s1_r     <= hblnk_in;
         vblnk_s1_r     <= vblnk_in;
         tgt_valid_s1_r <= tgt_valid;
         tgt_idx_s1_r   <= tgt_idx;
         blink_s1_r     <= blink_on_r;
      end
   end

   // Priority encoder: scanning from the top down leaves the lowest hit index.
   always_comb begin
      win_hit_s = 1'b0;
      win_idx_s = '0;
      for (int i = NUM_PADS - 1; i >= 0; i--) begin
         win_idx_s = hit_s1_r[i] ? IDX_W'(i) : win_idx_s;
         win_hit_s = win_hit_s | hit_s1_r[i];
      end
   end

   // Colour select for the winning pad.
   always_comb begin
      rgb_nxt_s = rgb_s1_r;
      if (win_hit_s && tgt_valid_s1_r && blink_s1_r && (win_idx_s == tgt_idx_s1_r)) begin
         rgb_nxt_s = COLOR_TGT;
      end else if (win_hit_s) begin
         rgb_nxt_s = COLOR_PAD;
      end else begin
         rgb_nxt_s = rgb_s1_r;
      end
   end

   // Stage 2: registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_out  <= '0;
         vcount_out  <= '0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b0;
         hblnk_out   <= 1'b0;
         vblnk_out   <= 1'b0;
         rgb_out     <= '0;
         pad_hit     <= 1'b0;
         pad_hit_idx <= '0;
      end else begin
         hcount_out  <= hcount_s1_r;
         vcount_out  <= vcount_s1_r;
         hsync_out   <= hsync_s1_r;
         vsync_out   <= vsync_s1_r;
         hblnk_out   <= hblnk_s1_r;
         vblnk_out   <= vblnk_s1_r;
         rgb_out     <= rgb_nxt_s;
         pad_hit     <= win_hit_s;
         pad_hit_idx <= win_idx_s;
      end
   end

endmodule

// File: tb/tb_draw_landing_pads.sv
// Directed self-checking bench for draw_landing_pads.
// Inputs change on the falling edge; outputs are checked on a falling edge
// two rising edges after the pixel was presented.
module tb_draw_landing_pads;

   localparam int NP = 4;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NP-1:0] pad_en = '0;
   logic          tgt_valid = 1'b0;
   logic [IW-1:0] tgt_idx = '0;
   logic          cfg_we = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [10:0]   cfg_x = '0, cfg_y = '0, cfg_w = '0;
   logic [10:0]   hcount_in = '0, vcount_in = '0;
   logic          hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0]   rgb_in = '0;
   logic [10:0]   hcount_out, vcount_out;
   logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0]   rgb_out;
   logic          pad_hit;
   logic [IW-1:0] pad_hit_idx;

   int checks = 0;
   int errors = 0;

   draw_landing_pads #(
      .NUM_PADS     (NP),
      .IDX_W        (IW),
      .BLINK_FRAMES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pad_en      (pad_en),
      .tgt_valid   (tgt_valid),
      .tgt_idx     (tgt_idx),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_x       (cfg_x),
      .cfg_y       (cfg_y),
      .cfg_w       (cfg_w),
      .hcount_in   (hcount_in),
      .vcount_in   (vcount_in),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .hblnk_in    (hblnk_in),
      .vblnk_in    (vblnk_in),
      .rgb_in      (rgb_in),
      .hcount_out  (hcount_out),
      .vcount_out  (vcount_out),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .hblnk_out   (hblnk_out),
      .vblnk_out   (vblnk_out),
      .rgb_out     (rgb_out),
      .pad_hit     (pad_hit),
      .pad_hit_idx (pad_hit_idx)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present one pixel and wait until its result is on the outputs.
   task automatic px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
      hcount_in = h;
      vcount_in = v;
      rgb_in    = rgb;
      repeat (2) @(negedge clk);
   endtask

   // Full pixel check: colour, hit flag and index.
   task automatic chk_px(input string tag, input logic [10:0] h, input logic [10:0] v,
                         input logic [11:0] rgb, input logic [11:0] exp_rgb,
                         input logic exp_hit, input logic [IW-1:0] exp_idx);
      px(h, v, rgb);
      check_val({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
      check_val({tag, "_hit"}, 32'(pad_hit), 32'(exp_hit));
      check_val({tag, "_idx"}, 32'(pad_hit_idx), 32'(exp_idx));
   endtask

   task automatic cfg_write(input logic [IW-1:0] idx, input logic [10:0] x,
                            input logic [10:0] y, input logic [10:0] w);
      cfg_we  = 1'b1;
      cfg_idx = idx;
      cfg_x   = x;
      cfg_y   = y;
      cfg_w   = w;
      @(negedge clk);
      cfg_we  = 1'b0;
   endtask

   task automatic vblank_pulse();
      vblnk_in = 1'b1;
      @(negedge clk);
      vblnk_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic vsync_pulse();
      vsync_in = 1'b1;
      @(negedge clk);
      vsync_in = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // Reset state with non-zero inputs applied
      hcount_in = 11'd10;
      vcount_in = 11'd560;
      rgb_in    = 12'habc;
      hsync_in  = 1'b1;
      pad_en    = 4'b1111;
      repeat (3) @(negedge clk);
      check_val("rst_rgb", 32'(rgb_out), 32'h0);
      check_val("rst_hit", 32'(pad_hit), 32'h0);
      check_val("rst_hcnt", 32'(hcount_out), 32'h0);
      check_val("rst_hsync", 32'(hsync_out), 32'h0);
      rst      = 1'b0;
      hsync_in = 1'b0;

      // 1: reset geometry, pad0 spans 10..124 x 560..579
      pad_en = 4'b0001;
      chk_px("t1_p0", 11'd10, 11'd560, 12'h123, 12'h0f0, 1'b1, 3'd0);
      chk_px("t1_pass", 11'd125, 11'd560, 12'h123, 12'h123, 1'b0, 3'd0);
      chk_px("t1_corner", 11'd124, 11'd579, 12'h123, 12'h0f0, 1'b1, 3'd0);
      chk_px("t1_below", 11'd124, 11'd580, 12'h123, 12'h123, 1'b0, 3'd0);

      // 2: latency of exactly two clocks
      pad_en    = 4'b0000;
      hcount_in = 11'd100;
      vcount_in = 11'd200;
      hsync_in  = 1'b1;
      hblnk_in  = 1'b1;
      rgb_in    = 12'habc;
      @(negedge clk);
      check_val("t2_hcnt_1clk", 32'(hcount_out), 32'd124);
      check_val("t2_hsync_1clk", 32'(hsync_out), 32'd0);
      @(negedge clk);
      check_val("t2_hcnt", 32'(hcount_out), 32'd100);
      check_val("t2_vcnt", 32'(vcount_out), 32'd200);
      check_val("t2_hsync", 32'(hsync_out), 32'd1);
      check_val("t2_hblnk", 32'(hblnk_out), 32'd1);
      check_val("t2_vsync", 32'(vsync_out), 32'd0);
      check_val("t2_rgb", 32'(rgb_out), 32'habc);
      hsync_in = 1'b0;
      hblnk_in = 1'b0;

      // 3: shadowed write, then a write in the commit cycle
      pad_en = 4'b0010;
      cfg_write(3'd1, 11'd300, 11'd560, 11'd50);
      chk_px("t3_old_new", 11'd300, 11'd560, 12'h111, 12'h111, 1'b0, 3'd0);
      chk_px("t3_old_old", 11'd170, 11'd560, 12'h111, 12'h0f0, 1'b1, 3'd1);
      vblnk_in = 1'b1;
      cfg_we   = 1'b1;
      cfg_idx  = 3'd1;
      cfg_x    = 11'd600;
      cfg_y    = 11'd560;
      cfg_w    = 11'd10;
      @(negedge clk);
      cfg_we   = 1'b0;
      vblnk_in = 1'b0;
      @(negedge clk);
      chk_px("t3_c1_new", 11'd300, 11'd560, 12'h111, 12'h0f0, 1'b1, 3'd1);
      chk_px("t3_c1_defer", 11'd600, 11'd560, 12'h111, 12'h111, 1'b0, 3'd0);
      chk_px("t3_c1_old", 11'd170, 11'd560, 12'h111, 12'h111, 1'b0, 3'd0);
      vblank_pulse();
      chk_px("t3_c2_new", 11'd600, 11'd560, 12'h111, 12'h0f0, 1'b1, 3'd1);
      chk_px("t3_c2_old", 11'd300, 11'd560, 12'h111, 12'h111, 1'b0, 3'd0);

      // 4: overlap, pad0 350..449 and pad2 320..434 both cover x=400
      cfg_write(3'd0, 11'd350, 11'd560, 11'd100);
      vblank_pulse();
      pad_en = 4'b0101;
      chk_px("t4_overlap", 11'd400, 11'd560, 12'h222, 12'h0f0, 1'b1, 3'd0);
      pad_en = 4'b0100;
      chk_px("t4_pad2", 11'd400, 11'd560, 12'h222, 12'h0f0, 1'b1, 3'd2);

      // 5: blink with BLINK_FRAMES=2 on pad1 (600..609)
      pad_en    = 4'b0010;
      tgt_idx   = 3'd1;
      tgt_valid = 1'b1;
      chk_px("t5_f0", 11'd600, 11'd560, 12'h333, 12'h0f0, 1'b1, 3'd1);
      vsync_pulse();
      chk_px("t5_f1", 11'd600, 11'd560, 12'h333, 12'h0f0, 1'b1, 3'd1);
      vsync_pulse();
      chk_px("t5_f2", 11'd600, 11'd560, 12'h333, 12'hff0, 1'b1, 3'd1);
      pad_en = 4'b0011;
      chk_px("t5_nontgt", 11'd400, 11'd560, 12'h333, 12'h0f0, 1'b1, 3'd0);
      pad_en = 4'b0010;
      vsync_pulse();
      chk_px("t5_f3", 11'd600, 11'd560, 12'h333, 12'hff0, 1'b1, 3'd1);
      vsync_pulse();
      chk_px("t5_f4", 11'd600, 11'd560, 12'h333, 12'h0f0, 1'b1, 3'd1);
      vsync_pulse();
      vsync_pulse();
      chk_px("t5_f6", 11'd600, 11'd560, 12'h333, 12'hff0, 1'b1, 3'd1);
      tgt_valid = 1'b0;
      chk_px("t5_tgt_off", 11'd600, 11'd560, 12'h333, 12'h0f0, 1'b1, 3'd1);
      tgt_valid = 1'b1;
      chk_px("t5_tgt_on", 11'd600, 11'd560, 12'h333, 12'hff0, 1'b1, 3'd1);
      tgt_valid = 1'b0;

      // 6: right-edge pad without wrap, zero width, out-of-range index
      cfg_write(3'd3, 11'd2040, 11'd560, 11'd20);
      cfg_write(3'd2, 11'd100, 11'd560, 11'd0);
      cfg_write(3'd5, 11'd0, 11'd0, 11'd2047);
      vblank_pulse();
      pad_en = 4'b1000;
      chk_px("t6_2040", 11'd2040, 11'd560, 12'h444, 12'h0f0, 1'b1, 3'd3);
      chk_px("t6_2039", 11'd2039, 11'd560, 12'h444, 12'h444, 1'b0, 3'd0);
      chk_px("t6_wrap0", 11'd5, 11'd560, 12'h444, 12'h444, 1'b0, 3'd0);
      pad_en = 4'b0100;
      chk_px("t6_w0", 11'd100, 11'd560, 12'h444, 12'h444, 1'b0, 3'd0);
      pad_en = 4'b1111;
      chk_px("t6_idx5", 11'd1000, 11'd100, 12'h555, 12'h555, 1'b0, 3'd0);
      chk_px("t6_2047", 11'd2047, 11'd560, 12'h444, 12'h0f0, 1'b1, 3'd3);

      // Reset mid-line clears outputs at once and restores reset geometry
      rst = 1'b1;
      #1;
      check_val("t6_rst_rgb", 32'(rgb_out), 32'h0);
      check_val("t6_rst_hit", 32'(pad_hit), 32'h0);
      check_val("t6_rst_idx", 32'(pad_hit_idx), 32'h0);
      check_val("t6_rst_hcnt", 32'(hcount_out), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      pad_en = 4'b0001;
      chk_px("t6_post_p0", 11'd10, 11'd560, 12'h666, 12'h0f0, 1'b1, 3'd0);
      pad_en = 4'b0010;
      chk_px("t6_post_p1", 11'd170, 11'd560, 12'h666, 12'h0f0, 1'b1, 3'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
